sseg_count_ctrl: RTL and testbench
==================================

// Module: sseg_count_ctrl
// PURPOSE
//  Parametrised value source for the seven-segment display path: debounces three
//  buttons, runs a prescaled up/down counter with four modes, and presents
//  DIGITS nibbles to the segment decoder/driver. Generalises the fixed 32-bit
//  free-running display counter: width, rate, direction, manual step, hold and clear.
// PARAMETERS
//  DIGITS       8      display digits; dat width = 4*DIGITS
//  PRESCALE     65536  clk cycles per auto step (>=2)
//  DBNC_CYCLES  65536  stable cycles required before a debounced level changes (>=1)
// PORTS
//  clk    in   1         system clock
//  rst    in   1         synchronous, active-high reset
//  btn_u  in   1         raw button up, asynchronous
//  btn_d  in   1         raw button down, asynchronous
//  btn_m  in   1         raw button mode, asynchronous
//  dat    out  4*DIGITS  count value, nibble i = digit i; registered
//  mode   out  2         00 UP, 01 DOWN, 10 MANUAL, 11 HOLD; registered
//  tick   out  1         1-cycle pulse, high in the first cycle a new dat value is visible
// BEHAVIOUR
//  - Reset, sync on clk with rst=1: dat=0, mode=UP, tick=0, prescaler=0,
//    synchronisers/debounced levels/counters=0. Reset mid-operation is allowed;
//    a press in progress is discarded.
//  - Each button: 2-FF synchroniser -> debounce counter. The counter increments
//    while the synced input differs from the debounced level; it clears when the
//    input matches. When it reaches DBNC_CYCLES, the level flips and the counter
//    clears. A debounced 0->1 edge gives a 1-cycle press pulse (registered).
//  - Press latency: raw edge held stable -> dat/mode update in DBNC_CYCLES+4 cycles.
//  - Release edges and glitches shorter than DBNC_CYCLES produce nothing.
//  - Prescaler counts 0..PRESCALE-1 and wraps; step=1 on the terminal count.
//  - Mode FSM, advanced by a btn_m press: UP->DOWN->MANUAL->HOLD->UP.
//    On any mode change the prescaler clears to 0 and a same-cycle step is dropped.
//  - Priority per cycle, highest first:
//    1. btn_u & btn_d press in the same cycle, any mode: dat<=0. tick=1 even if dat was already 0.
//    2. btn_m press: change mode only; dat holds.
//    3. UP: step -> dat+1.  DOWN: step -> dat-1.
//    4. MANUAL: btn_u press -> +1, btn_d press -> -1; steps ignored.
//    5. HOLD: dat frozen.
//    Single u/d presses in UP/DOWN/HOLD are ignored.
//  - Wrap: hex mode is modulo 2^(4*DIGITS): all-F+1 -> 0, 0-1 -> all-F. tick fires on wrap.
//  - tick is registered alongside dat; it is 0 in every cycle with no update.
// CONFIGURATION
//  SSEG_CNT_BCD_EN defined: each nibble counts 0-9 with decimal carry/borrow
//    (0..09 -1 -> 99..9, 99..9 +1 -> 0). No nibble ever exceeds 9.
//  SSEG_CNT_BCD_EN undefined: plain binary count over 4*DIGITS bits (hex display).
// TESTING  (DIGITS=2, PRESCALE=4, DBNC_CYCLES=3)
//  - Reset, UP, run 40 cycles -> dat 00,01,..,0A at 4-cycle spacing; tick once per step.
//  - Hex, UP: preload to FF via MANUAL, return to UP, next step -> dat=00, tick=1.
//    BCD: 99+1 -> 00. DOWN from 00 -> FF (hex) / 99 (BCD).
//  - btn_m held stable -> mode advances exactly once, 7 cycles after the raw edge.
//    A 2-cycle btn_m glitch -> no change.
//  - MANUAL, btn_u pressed 3 times then btn_d once -> dat=02; prescaler steps ignored.
//  - btn_u+btn_d rising together, in HOLD with dat=37 -> dat=00 and tick=1.
//    In HOLD a single btn_u -> no change.
//  - rst=1 for 1 cycle mid-count, in DOWN with dat=05 -> next cycle dat=00, mode=UP, tick=0.

Source files
------------

// File: rtl/sseg_count_ctrl.sv
// Seven-segment value source: three debounced buttons drive a prescaled up/down counter with four modes.
// Define SSEG_CNT_BCD_EN for per-nibble decimal counting; without it the count is plain binary (hex display).
module sseg_count_ctrl #(
    parameter int DIGITS      = 8,
    parameter int PRESCALE    = 65536,
    parameter int DBNC_CYCLES = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_u,
    input  logic                btn_d,
    input  logic                btn_m,
    output logic [4*DIGITS-1:0] dat,
    output logic [1:0]          mode,
    output logic                tick
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DBNC_CYCLES + 1);
    localparam int BU = 0;
    localparam int BD = 1;
    localparam int BM = 2;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_MANUAL = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    logic [2:0]    sync1_q, sync2_q, level_q, level_prev_q, press_q;
    logic [DW-1:0] dbnc_q [3];
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  dat_q, dat_d;
    mode_e         mode_q, mode_d;
    logic          tick_q, tick_d;
    logic          step;

    // Button front end: bit 0 up, bit 1 down, bit 2 mode.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            press_q      <= '0;
            for (int i = 0; i < 3; i++) dbnc_q[i] <= '0;
        end else begin
            sync1_q      <= {btn_m, btn_d, btn_u};
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    dbnc_q[i] <= '0;
                end else if (dbnc_q[i] == DW'(DBNC_CYCLES - 1)) begin
                    level_q[i] <= ~level_q[i];
                    dbnc_q[i]  <= '0;
                end else begin
                    dbnc_q[i] <= dbnc_q[i] + DW'(1);
                end
            end
        end
    end

`ifdef SSEG_CNT_BCD_EN
    function automatic logic [W-1:0] cnt_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] cnt_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction
`else
    function automatic logic [W-1:0] cnt_inc(input logic [W-1:0] v);
        return v + W'(1);
    endfunction

    function automatic logic [W-1:0] cnt_dec(input logic [W-1:0] v);
        return v - W'(1);
    endfunction
`endif

    assign step = (presc_q == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            dat_q   <= '0;
            mode_q  <= MODE_UP;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            dat_q   <= dat_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mode_d  = mode_q;
        dat_d   = dat_q;
        tick_d  = 1'b0;
        presc_d = step ? '0 : presc_q + PW'(1);
        if (press_q[BU] && press_q[BD]) begin
            dat_d  = '0;
            tick_d = 1'b1;
        end else if (press_q[BM]) begin
            // A mode change restarts the rate and swallows any step landing in this cycle.
            presc_d = '0;
            unique case (mode_q)
                MODE_UP:     mode_d = MODE_DOWN;
                MODE_DOWN:   mode_d = MODE_MANUAL;
                MODE_MANUAL: mode_d = MODE_HOLD;
                MODE_HOLD:   mode_d = MODE_UP;
            endcase
        end else begin
            unique case (mode_q)
                MODE_UP: if (step) begin
                    dat_d  = cnt_inc(dat_q);
                    tick_d = 1'b1;
                end
                MODE_DOWN: if (step) begin
                    dat_d  = cnt_dec(dat_q);
                    tick_d = 1'b1;
                end
                MODE_MANUAL: if (press_q[BU]) begin
                    dat_d  = cnt_inc(dat_q);
                    tick_d = 1'b1;
                end else if (press_q[BD]) begin
                    dat_d  = cnt_dec(dat_q);
                    tick_d = 1'b1;
                end
                MODE_HOLD: ;
            endcase
        end
    end

    assign dat  = dat_q;
    assign mode = mode_q;
    assign tick = tick_q;
endmodule

// File: tb/tb_sseg_count_ctrl.sv
// Bench for sseg_count_ctrl: randomised button presses checked against a cycle-count/arithmetic model.
// Follows SSEG_CNT_BCD_EN so the same bench covers the hex and decimal builds.
module tb_sseg_count_ctrl;
    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int DBNC     = 3;
    localparam int W        = 4 * DIGITS;
`ifdef SSEG_CNT_BCD_EN
    localparam bit BCD = 1'b1;
`else
    localparam bit BCD = 1'b0;
`endif
    localparam int MOD_N = BCD ? 10 ** DIGITS : 2 ** W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn_u = 1'b0, btn_d = 1'b0, btn_m = 1'b0;
    logic [W-1:0] dat;
    logic [1:0]   mode;
    logic         tick;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = -1;
    int ok_cyc = 0;

    // Model: displayed value as a plain number, mode index, cycles since the rate restarted.
    int m_num = 0, m_mode = 0, m_presc = 0;
    bit m_tick = 1'b0;
    int q_u[$], q_d[$], q_m[$];

    sseg_count_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DBNC_CYCLES(DBNC)) dut (
        .clk(clk), .rst(rst), .btn_u(btn_u), .btn_d(btn_d), .btn_m(btn_m),
        .dat(dat), .mode(mode), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [W-1:0] from_num(input int n);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = n;
        if (!BCD) return W'(n);
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int to_num(input logic [W-1:0] v);
        int n;
        n = 0;
        if (!BCD) return int'(v);
        for (int i = 0; i < DIGITS; i++) n += int'(v[4*i +: 4]) * (10 ** i);
        return n;
    endfunction

    // One clock: apply the rules to the model at the edge, return at the following falling edge.
    task automatic step();
        bit pu, pd, pm, st;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_num = 0; m_mode = 0; m_presc = 0; m_tick = 1'b0;
            q_u.delete(); q_d.delete(); q_m.delete();
        end else begin
            pu = (q_u.size() > 0 && q_u[0] == cyc);
            pd = (q_d.size() > 0 && q_d[0] == cyc);
            pm = (q_m.size() > 0 && q_m[0] == cyc);
            if (pu) void'(q_u.pop_front());
            if (pd) void'(q_d.pop_front());
            if (pm) void'(q_m.pop_front());
            st      = (m_presc % PRESCALE == PRESCALE - 1);
            m_presc = (m_presc + 1) % PRESCALE;
            m_tick  = 1'b0;
            if (pu && pd) begin
                m_num = 0; m_tick = 1'b1;
            end else if (pm) begin
                m_mode = (m_mode + 1) % 4; m_presc = 0;
            end else if (m_mode == 0 && st) begin
                m_num = (m_num + 1) % MOD_N; m_tick = 1'b1;
            end else if (m_mode == 1 && st) begin
                m_num = (m_num + MOD_N - 1) % MOD_N; m_tick = 1'b1;
            end else if (m_mode == 2 && pu) begin
                m_num = (m_num + 1) % MOD_N; m_tick = 1'b1;
            end else if (m_mode == 2 && pd) begin
                m_num = (m_num + MOD_N - 1) % MOD_N; m_tick = 1'b1;
            end
        end
        @(negedge clk);
        if (cyc == rel_cyc) begin
            btn_u = 1'b0; btn_d = 1'b0; btn_m = 1'b0;
        end
    endtask

    // Clean press: raw level held 5 cycles; it takes effect DBNC+4 cycles after the raw edge.
    task automatic raise(input bit u, input bit d, input bit m);
        if (u) q_u.push_back(cyc + DBNC + 4);
        if (d) q_d.push_back(cyc + DBNC + 4);
        if (m) q_m.push_back(cyc + DBNC + 4);
        btn_u = u; btn_d = d; btn_m = m;
        rel_cyc = cyc + 5;
        ok_cyc  = cyc + 11;
    endtask

    task automatic settle();
        while (cyc < ok_cyc) step();
    endtask

    task automatic press(input bit u, input bit d, input bit m);
        raise(u, d, m);
        settle();
        repeat ($urandom_range(0, 3)) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        checks++; if (dat !== '0) begin errors++; $display("FAIL reset_dat got=%h want=00", dat); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d want=0", mode); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", tick); end
    endtask

    task automatic test_up_count();
        int nt;
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick === 1'b1) nt++;
            checks++;
            if (dat !== from_num(m_num) || tick !== m_tick) begin
                errors++;
                $display("FAIL up_count cyc=%0d dat=%h want=%h tick=%b want=%b", cyc, dat, from_num(m_num), tick, m_tick);
            end
        end
        checks++; if (nt != 10) begin errors++; $display("FAIL up_tick_count got=%0d want=10", nt); end
        checks++; if (dat !== from_num(10)) begin errors++; $display("FAIL up_final got=%h want=%h", dat, from_num(10)); end
    endtask

    task automatic test_mode_latency();
        int chg;
        logic [1:0] m0;
        chg = -1;
        m0 = mode;
        raise(1'b0, 1'b0, 1'b1);
        for (int off = 1; off <= 10; off++) begin
            step();
            if (mode !== m0 && chg < 0) chg = off;
            checks++;
            if (mode !== 2'(m_mode) || dat !== from_num(m_num)) begin
                errors++;
                $display("FAIL mode_lat cyc=%0d mode=%0d want=%0d dat=%h want=%h", cyc, mode, m_mode, dat, from_num(m_num));
            end
        end
        checks++; if (chg != DBNC + 4) begin errors++; $display("FAIL mode_lat_offset got=%0d want=%0d", chg, DBNC + 4); end
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL mode_after_m got=%0d want=1", mode); end
        settle();
    endtask

    task automatic test_glitch();
        logic [1:0] m0;
        m0 = mode;
        btn_m = 1'b1;
        repeat (2) step();
        btn_m = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (mode !== m0 || dat !== from_num(m_num) || tick !== m_tick) begin
                errors++;
                $display("FAIL glitch cyc=%0d mode=%0d want=%0d dat=%h want=%h", cyc, mode, m0, dat, from_num(m_num));
            end
        end
    endtask

    task automatic test_down_wrap();
        int e;
        bit seen;
        seen = 1'b0;
        e = cyc + DBNC + 4;
        raise(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (cyc == e) begin
                checks++;
                if (dat !== '0 || tick !== 1'b1) begin errors++; $display("FAIL down_clear dat=%h tick=%b want=00/1", dat, tick); end
            end else if (cyc > e && tick === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (dat !== from_num(MOD_N - 1)) begin errors++; $display("FAIL down_wrap got=%h want=%h", dat, from_num(MOD_N - 1)); end
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL down_wrap_timeout no step after clear"); end
        settle();
    endtask

    task automatic test_up_wrap();
        int e;
        bit seen;
        seen = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (dat !== from_num(MOD_N - 1) || mode !== 2'd2) begin
            errors++; $display("FAIL manual_preload dat=%h mode=%0d want=%h/2", dat, mode, from_num(MOD_N - 1));
        end
        press(1'b0, 1'b0, 1'b1);
        e = cyc + DBNC + 4;
        raise(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (cyc > e && tick === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (dat !== '0 || mode !== 2'd0) begin errors++; $display("FAIL up_wrap dat=%h mode=%0d want=00/0", dat, mode); end
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL up_wrap_timeout no step after return to UP"); end
        settle();
    endtask

    task automatic test_manual();
        int k;
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b1, 1'b0);
        repeat (3) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (dat !== from_num(2) || mode !== 2'd2) begin errors++; $display("FAIL manual_seq dat=%h mode=%0d want=%h/2", dat, mode, from_num(2)); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (dat !== from_num(2) || tick !== 1'b0) begin errors++; $display("FAIL manual_idle cyc=%0d dat=%h tick=%b", cyc, dat, tick); end
        end
        for (int i = 0; i < 10; i++) begin
            k = $urandom_range(0, 2);
            press(k != 1, k != 0, 1'b0);
            checks++;
            if (dat !== from_num(m_num) || mode !== 2'(m_mode)) begin
                errors++; $display("FAIL manual_rand i=%0d dat=%h want=%h", i, dat, from_num(m_num));
            end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] tv;
        int n, e;
        bit seen;
        seen = 1'b0;
        tv = 8'h37;
        n = (to_num(tv) - m_num + MOD_N) % MOD_N;
        repeat (n) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (dat !== tv || mode !== 2'd3) begin errors++; $display("FAIL hold_entry dat=%h mode=%0d want=37/3", dat, mode); end
        raise(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (dat !== tv || tick !== 1'b0) begin errors++; $display("FAIL hold_single_u cyc=%0d dat=%h tick=%b", cyc, dat, tick); end
        end
        settle();
        e = cyc + DBNC + 4;
        raise(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (cyc == e) begin
                seen = 1'b1;
                checks++;
                if (dat !== '0 || tick !== 1'b1 || mode !== 2'd3) begin
                    errors++; $display("FAIL hold_clear dat=%h tick=%b mode=%0d want=00/1/3", dat, tick, mode);
                end
            end
        end
        if (!seen) begin checks++; errors++; $display("FAIL hold_clear_timeout"); end
        settle();
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 1500 && !found; i++) begin
            step();
            if (m_num == 5 && m_tick) found = 1'b1;
            if (i % 16 == 0 || found) begin
                checks++;
                if (dat !== from_num(m_num) || mode !== 2'(m_mode)) begin
                    errors++; $display("FAIL down_run cyc=%0d dat=%h want=%h mode=%0d", cyc, dat, from_num(m_num), mode);
                end
            end
        end
        if (!found) begin checks++; errors++; $display("FAIL reset_mid_timeout never reached 05"); end
        checks++;
        if (dat !== from_num(5) || mode !== 2'd1) begin errors++; $display("FAIL pre_reset dat=%h mode=%0d want=05/1", dat, mode); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (dat !== '0 || mode !== 2'd0 || tick !== 1'b0) begin
            errors++; $display("FAIL reset_mid dat=%h mode=%0d tick=%b want=00/0/0", dat, mode, tick);
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_mode_latency();
        test_glitch();
        test_down_wrap();
        test_up_wrap();
        test_manual();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
